// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;
   localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

   typedef enum logic [2:0] {
      IDLE,
      ABS,
      ITER,
      FIX,
      DONE
   } state_t;

   function automatic int div_cnt_width(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/div_neg.sv
// Dual-lane conditional two's-complement negation, shared between operand
// magnitude (ABS) and result sign correction (FIX).
module div_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic             i_a_en,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_b_en,
   output logic [WIDTH-1:0] o_a,
   output logic [WIDTH-1:0] o_b
);

   assign o_a = i_a_en ? ('0 - i_a) : i_a;
   assign o_b = i_b_en ? ('0 - i_b) : i_b;

endmodule

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial
// subtract the divisor, keep or restore R and set the new quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_r,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH:0]   o_r,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0]   w_rsh;
   logic [WIDTH+1:0] w_sub;
   logic             w_ge;

   assign w_rsh = {i_r[WIDTH-1:0], i_q[WIDTH-1]};
   assign w_sub = {1'b0, w_rsh} - {2'b00, i_d};
   // A set R MSB means the shifted value exceeds any divisor, so the step succeeds.
   assign w_ge  = i_r[WIDTH] | ~w_sub[WIDTH+1];

   assign o_r = w_ge ? w_sub[WIDTH:0] : w_rsh;
   assign o_q = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq.sv
// Signed restoring divider: quotient to LO, remainder to HI; done 35 cycles
// after an accepted start (2 on a trapped divide-by-zero when DIV_ZERO_TRAP_EN is defined).
// No backpressure: start is only sampled in IDLE; starts while busy or in DONE are dropped.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int CW = div_cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH:0]   r_rem;
   logic [CW-1:0]    r_cnt;
   logic             r_qsign;
   logic             r_rsign;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remo;

   logic             w_trap;
   logic [WIDTH-1:0] w_neg_b_in;
   logic             w_neg_a_en;
   logic             w_neg_b_en;
   logic [WIDTH-1:0] w_neg_a;
   logic [WIDTH-1:0] w_neg_b;
   logic [WIDTH:0]   w_step_r;
   logic [WIDTH-1:0] w_step_q;

`ifdef DIV_ZERO_TRAP_EN
   assign w_trap = (r_dvs == '0);
`else
   assign w_trap = 1'b0;
`endif

   // Negation lanes carry the operands in ABS and the raw results in FIX.
   always_comb begin
      w_neg_b_in = r_rem[WIDTH-1:0];
      w_neg_a_en = r_qsign;
      w_neg_b_en = r_rsign;
      if (r_state == ABS) begin
         w_neg_b_in = r_dvs;
         w_neg_a_en = r_q[WIDTH-1];
         w_neg_b_en = r_dvs[WIDTH-1];
      end
   end

   div_neg #(.WIDTH(WIDTH)) u_neg (
      .i_a    (r_q),
      .i_a_en (w_neg_a_en),
      .i_b    (w_neg_b_in),
      .i_b_en (w_neg_b_en),
      .o_a    (w_neg_a),
      .o_b    (w_neg_b)
   );

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_r (r_rem),
      .i_q (r_q),
      .i_d (r_dvs),
      .o_r (w_step_r),
      .o_q (w_step_q)
   );

   always_ff @(posedge clock) begin
      if (clear) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = ABS;
         ABS:     w_next = w_trap ? DONE : ITER;
         ITER:    if (r_cnt == '0) w_next = FIX;
         FIX:     w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == ABS) || (r_state == ITER) || (r_state == FIX);
      done = (r_state == DONE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_q     <= '0;
         r_dvs   <= '0;
         r_rem   <= '0;
         r_cnt   <= '0;
         r_qsign <= 1'b0;
         r_rsign <= 1'b0;
         r_quot  <= '0;
         r_remo  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_q     <= dividend;
                  r_dvs   <= divisor;
                  r_qsign <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  r_rsign <= dividend[WIDTH-1];
               end
            end
            ABS: begin
               r_q   <= w_neg_a;
               r_dvs <= w_neg_b;
               r_rem <= '0;
               r_cnt <= CW'(WIDTH - 1);
               if (w_trap) begin
                  r_quot <= '0;
                  r_remo <= r_q;
               end
            end
            ITER: begin
               r_rem <= w_step_r;
               r_q   <= w_step_q;
               r_cnt <= r_cnt - 1'b1;
            end
            FIX: begin
               r_quot <= w_neg_a;
               r_remo <= w_neg_b;
            end
            default: ;
         endcase
      end
   end

`ifdef DIV_ZERO_TRAP_EN
   logic r_dz;

   always_ff @(posedge clock) begin
      if (clear)                         r_dz <= 1'b0;
      else if (r_state == ABS && w_trap) r_dz <= 1'b1;
      else if (r_state == FIX)           r_dz <= 1'b0;
   end

   assign div_zero = r_dz;
`else
   assign div_zero = 1'b0;
`endif

   assign quotient  = r_quot;
   assign remainder = r_remo;

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq; expectations queued at issue, checked on done.
module tb_div_seq;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         clear;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
      int           bsy;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   ecnt      = 0;
   int   busy_cnt  = 0;
   int   done_seen = 0;

`ifdef DIV_ZERO_TRAP_EN
   localparam logic [W-1:0] Z7_Q  = 32'h0000_0000;
   localparam logic [W-1:0] ZN7_Q = 32'h0000_0000;
   localparam logic         Z_DZ  = 1'b1;
   localparam int           Z_LAT = 2;
   localparam int           Z_BSY = 1;
`else
   localparam logic [W-1:0] Z7_Q  = 32'hFFFF_FFFF;
   localparam logic [W-1:0] ZN7_Q = 32'h0000_0001;
   localparam logic         Z_DZ  = 1'b0;
   localparam int           Z_LAT = 35;
   localparam int           Z_BSY = 34;
`endif

   always #5 clock = ~clock;

   always @(posedge clock) ecnt <= ecnt + 1;

   div_seq #(.WIDTH(W)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per done pulse.
   always @(negedge clock) begin
      if (clear) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (done) begin
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 expected=0 q=%h r=%h", quotient, remainder);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
            chk("latency", W'(ecnt - e.acc + 1), W'(e.lat));
            chk("busy_cycles", W'(busy_cnt), W'(e.bsy));
         end
         busy_cnt = 0;
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic push,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                        input int lat, input int bsy);
      exp_t e;
      @(negedge clock);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      if (push) begin
         e.q   = eq;
         e.r   = er;
         e.dz  = edz;
         e.lat = lat;
         e.bsy = bsy;
         e.acc = ecnt;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clock);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL done_timeout actual_pending=%0d expected_pending=0", sb.size());
         sb.delete();
      end
      @(negedge clock);
   endtask

   initial begin
      int d0;
      clear    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
      clear = 1'b0;

      issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 35, 34);                    drain();
      issue(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, 34);   drain();
      issue(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0, 35, 34);           drain();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 35, 34); drain();
      issue(32'd7, 32'd0, 1'b1, Z7_Q, 32'd7, Z_DZ, Z_LAT, Z_BSY);                   drain();
      issue(-32'sd7, 32'd0, 1'b1, ZN7_Q, 32'hFFFF_FFF9, Z_DZ, Z_LAT, Z_BSY);        drain();
      issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, 32'h7FFF_FFFF, 1'b0, 35, 34); drain();

      // Start while busy must be dropped.
      issue(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 35, 34);
      repeat (5) @(negedge clock);
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      drain();

      // Start in the DONE cycle must be dropped.
      issue(32'd20, 32'd6, 1'b1, 32'd3, 32'd2, 1'b0, 35, 34);
      for (int i = 0; i < 60 && !done; i++) @(negedge clock);
      start    = 1'b1;
      dividend = 32'd50;
      divisor  = 32'd3;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(negedge clock);
      chk("busy_after_done_start", {31'b0, busy}, 32'd0);
      drain();

      // Clear mid-operation: outputs zeroed, no done pulse ever appears.
      issue(32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 0);
      repeat (9) @(negedge clock);
      clear = 1'b1;
      repeat (2) @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      chk("clr_busy", {31'b0, busy}, 32'd0);
      chk("clr_done", {31'b0, done}, 32'd0);
      chk("clr_quotient", quotient, 32'd0);
      chk("clr_remainder", remainder, 32'd0);
      chk("clr_div_zero", {31'b0, div_zero}, 32'd0);
      d0 = done_seen;
      repeat (45) @(negedge clock);
      chk("no_done_after_clear", W'(done_seen), W'(d0));

      issue(32'd50, 32'd3, 1'b1, 32'd16, 32'd2, 1'b0, 35, 34); drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
